ex_muldiv_unit: RTL and testbench
=================================

Name: ex_muldiv_unit

Overview:
- Iterative RV32M multiply/divide unit that sits beside the EX-stage ALU.
- It sequences a shared 32-step shift/add-subtract datapath that serves all eight M-extension ops.
- It drives the EX stall request so the pipeline holds while the unit is busy.
- Its result is muxed onto the EX result path by the pipeline top when the control word selects it.

Parameters:
- XLEN, 32, operand/result width; only 32 is supported.
- ITER, 32, iterations per op; must equal XLEN.

Ports:
- clk  input  1  pipeline clock
- rst  input  1  synchronous, active-high reset
- start  input  1  EX holds a valid M-type instruction (held high while stalled)
- funct3  input  3  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
- a  input  32  rs1 value (post-forwarding)
- b  input  32  rs2 value (post-forwarding)
- hold  input  1  external stall (e.g. MEM miss); pipeline will not advance this cycle
- flush  input  1  kill the EX instruction (branch mispredict/redirect)
- ex_stall  output  1  request EX and earlier stages to stall
- done  output  1  result valid this cycle
- result  output  32  op result

Behaviour:
- Clock is clk. Reset is rst, synchronous, active-high. The reset state is IDLE with done=0, result=0, ex_stall=0, and the iteration counter at 0.
- States: IDLE, CALC, DONE.
- IDLE:
  - On start=1 and flush=0, capture operands: absolute values plus sign flags per funct3.
  - Signed ops: MULH and DIV/REM both operands; MULHSU only a. Unsigned ops: none.
  - Clear the accumulator/remainder, set count=0, go to CALC.
- Special cases, IDLE->DONE directly (1-cycle latency):
  - Divide by zero: DIV/DIVU give result=0xFFFFFFFF; REM/REMU give result=a.
  - Signed overflow, a=0x80000000 and b=0xFFFFFFFF: DIV gives 0x80000000; REM gives 0.
- CALC:
  - One iteration per cycle.
  - Multiply: shift-add over 64-bit product.
  - Divide: restoring, 33-bit partial remainder with a trial subtract.
  - count increments by 1. On count==31, apply sign correction: two's-complement negate when the sign flags differ; the remainder takes the dividend's sign.
  - On count==31, select the low or high 32 bits, or quotient or remainder, per funct3. Register the result and go to DONE.
- Normal latency: start seen in cycle T gives done=1 in cycle T+33.
- DONE:
  - done=1 and result is stable.
  - If hold=0, go to IDLE next cycle, since the pipeline advances.
  - If hold=1, stay in DONE with done and result unchanged. There is no recompute for the same instruction.
- ex_stall = start & ~flush & (state != DONE). It is combinational, so it is high in the IDLE cycle that accepts start and in every CALC cycle.
- flush=1 in any state: go to IDLE next cycle, done=0, result keeps its last value, no result is produced. flush has priority over start and over completion.
- start dropping to 0 mid-CALC without flush is illegal. An SVA assertion checks it; no recovery behaviour is defined.
- Reset mid-operation: IDLE next cycle; the in-flight op is discarded.
- result changes only on entry to DONE or on reset.

Optional Feature:
- Macro: MULDIV_FAST_MUL_EN.
- Defined: funct3 0-3 use a single-cycle 33x33 signed multiplier, so IDLE->DONE in 1 cycle (done at T+1). Division still iterates.
- Undefined: every multiply takes the 32-iteration CALC path (done at T+33). No multiplier macro is inferred.

Test Plan:
- MUL a=7, b=-3 (0xFFFFFFFD), start held, hold=0 -> ex_stall high for cycles T..T+32; done=1 at T+33 only; result=0xFFFFFFEB.
- MULHU a=0xFFFFFFFF, b=0xFFFFFFFF -> result=0xFFFFFFFE. MULHSU a=-1, b=2 -> result=0xFFFFFFFF.
- DIV a=-20, b=6 -> result=0xFFFFFFFD (-3). REM with the same operands -> 0xFFFFFFFE (-2). DIVU a=100, b=7 -> 14. REMU with the same operands -> 2.
- DIVU a=5, b=0 -> done at T+1, result=0xFFFFFFFF. REM a=5, b=0 -> 5. DIV a=0x80000000, b=-1 -> 0x80000000 at T+1.
- DIV in progress, flush at T+10 -> state IDLE at T+11, done never asserts. A new MUL 3*4 started at T+11 -> result 12 at T+44.
- MUL 6*7 reaches DONE with hold=1 for 3 cycles -> done=1 and result=42 for 3 cycles, ex_stall=0. After hold drops -> IDLE, no second done.

Source files
------------

// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide unit beside the EX-stage ALU; requests an EX stall while busy.
// Optional build macro MULDIV_FAST_MUL_EN: single-cycle multiply for funct3 0-3, division still iterates.
module ex_muldiv_unit #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned ITER = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            hold,
  input  logic            flush,
  output logic            ex_stall,
  output logic            done,
  output logic [XLEN-1:0] result
);
  localparam int unsigned     CW   = $clog2(ITER);
  localparam logic [CW-1:0]   LAST = CW'(ITER - 1);
  localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   count_q, count_d;
  logic [XLEN-1:0] acc_q, acc_d, lo_q, lo_d, opnd_q, opnd_d, result_q, result_d;
  logic [2:0]      f3_q, f3_d;
  logic            sa_q, sa_d, neg_q, neg_d, done_q, done_d;

  logic              a_sgn, b_sgn, sa_in, sb_in, is_div, div_zero, div_ovf;
  logic [XLEN-1:0]   addend, step_acc, step_lo, quot, rem, final_res;
  logic [XLEN:0]     mul_sum, div_sh;
  logic              div_ge;
  logic [2*XLEN-1:0] prod, prod_s;

  function automatic logic [XLEN-1:0] neg(input logic [XLEN-1:0] x);
    return ~x + XLEN'(1);
  endfunction

  // Operand sign handling and special-case detection for the op being offered.
  always_comb begin
    a_sgn    = (funct3 == 3'd1) || (funct3 == 3'd2) || (funct3 == 3'd4) || (funct3 == 3'd6);
    b_sgn    = (funct3 == 3'd1) || (funct3 == 3'd4) || (funct3 == 3'd6);
    sa_in    = a_sgn & a[XLEN-1];
    sb_in    = b_sgn & b[XLEN-1];
    is_div   = funct3[2];
    div_zero = is_div && (b == '0);
    div_ovf  = is_div && !funct3[0] && (a == SMIN) && (b == '1);
  end

  // Shared iteration step: acc is product-high / partial remainder, lo is multiplier / dividend-quotient.
  always_comb begin
    addend  = lo_q[0] ? opnd_q : '0;
    mul_sum = {1'b0, acc_q} + {1'b0, addend};
    div_sh  = {acc_q, lo_q[XLEN-1]};
    div_ge  = div_sh >= {1'b0, opnd_q};
    if (f3_q[2]) begin
      step_acc = div_ge ? XLEN'(div_sh - {1'b0, opnd_q}) : div_sh[XLEN-1:0];
      step_lo  = {lo_q[XLEN-2:0], div_ge};
    end else begin
      step_acc = mul_sum[XLEN:1];
      step_lo  = {mul_sum[0], lo_q[XLEN-1:1]};
    end
    prod   = {step_acc, step_lo};
    prod_s = neg_q ? (~prod + (2*XLEN)'(1)) : prod;
    quot   = neg_q ? neg(step_lo) : step_lo;
    rem    = sa_q ? neg(step_acc) : step_acc;
    case (f3_q)
      3'd0:                final_res = prod_s[XLEN-1:0];
      3'd1, 3'd2, 3'd3:    final_res = prod_s[2*XLEN-1:XLEN];
      3'd4, 3'd5:          final_res = quot;
      default:             final_res = rem;
    endcase
  end

`ifdef MULDIV_FAST_MUL_EN
  logic signed [XLEN:0]     fm_a, fm_b;
  logic signed [2*XLEN-1:0] fm_p;
  logic [XLEN-1:0]          fast_res;

  always_comb begin
    fm_a     = {a_sgn & a[XLEN-1], a};
    fm_b     = {b_sgn & b[XLEN-1], b};
    fm_p     = (2*XLEN)'(fm_a) * (2*XLEN)'(fm_b);
    fast_res = (funct3 == 3'd0) ? fm_p[XLEN-1:0] : fm_p[2*XLEN-1:XLEN];
  end
`endif

  // Next-state logic; flush overrides everything and leaves result untouched.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    acc_d    = acc_q;
    lo_d     = lo_q;
    opnd_d   = opnd_q;
    f3_d     = f3_q;
    sa_d     = sa_q;
    neg_d    = neg_q;
    done_d   = 1'b0;
    result_d = result_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          f3_d    = funct3;
          sa_d    = sa_in;
          neg_d   = sa_in ^ sb_in;
          lo_d    = sa_in ? neg(a) : a;
          opnd_d  = sb_in ? neg(b) : b;
          acc_d   = '0;
          count_d = '0;
          if (div_zero) begin
            result_d = funct3[1] ? a : '1;
            done_d   = 1'b1;
            state_d  = DONE;
          end else if (div_ovf) begin
            result_d = funct3[1] ? '0 : SMIN;
            done_d   = 1'b1;
            state_d  = DONE;
          end
`ifdef MULDIV_FAST_MUL_EN
          else if (!is_div) begin
            result_d = fast_res;
            done_d   = 1'b1;
            state_d  = DONE;
          end
`endif
          else begin
            state_d = CALC;
          end
        end
      end
      CALC: begin
        acc_d   = step_acc;
        lo_d    = step_lo;
        count_d = count_q + CW'(1);
        if (count_q == LAST) begin
          result_d = final_res;
          done_d   = 1'b1;
          state_d  = DONE;
        end
      end
      DONE: begin
        if (hold) done_d = 1'b1;
        else      state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (flush) begin
      state_d  = IDLE;
      done_d   = 1'b0;
      result_d = result_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      count_q  <= '0;
      acc_q    <= '0;
      lo_q     <= '0;
      opnd_q   <= '0;
      f3_q     <= '0;
      sa_q     <= 1'b0;
      neg_q    <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      acc_q    <= acc_d;
      lo_q     <= lo_d;
      opnd_q   <= opnd_d;
      f3_q     <= f3_d;
      sa_q     <= sa_d;
      neg_q    <= neg_d;
      done_q   <= done_d;
      result_q <= result_d;
    end
  end

  assign ex_stall = start & ~flush & (state_q != DONE);
  assign done     = done_q;
  assign result   = result_q;

  // Dropping start during an iteration without a flush is a pipeline bug.
  a_start_held: assert property (@(posedge clk) disable iff (rst)
    (state_q == CALC && !flush) |-> start);

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Self-checking bench for ex_muldiv_unit: directed cases plus random ops against an arithmetic model.
module tb_ex_muldiv_unit;
  logic        clk = 1'b0;
  logic        rst, start, hold, flush;
  logic [2:0]  funct3;
  logic [31:0] a, b;
  logic        ex_stall, done;
  logic [31:0] result;

  int          total = 0;
  int          bad   = 0;
  logic [31:0] last_res = '0;
  string       cur = "reset";

  ex_muldiv_unit dut (
    .clk(clk), .rst(rst), .start(start), .funct3(funct3), .a(a), .b(b),
    .hold(hold), .flush(flush), .ex_stall(ex_stall), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  // Reference: RV32M semantics from 64-bit arithmetic.
  function automatic logic [31:0] ref_res(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
    longint      sx, sy, ux, uy, p;
    logic [63:0] pu;
    logic        ovf;
    sx  = longint'($signed(x));
    sy  = longint'($signed(y));
    ux  = longint'({32'b0, x});
    uy  = longint'({32'b0, y});
    ovf = (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF);
    case (f)
      3'd0: begin p = sx * sy; return p[31:0]; end
      3'd1: begin p = sx * sy; return p[63:32]; end
      3'd2: begin p = sx * uy; return p[63:32]; end
      3'd3: begin pu = {32'b0, x} * {32'b0, y}; return pu[63:32]; end
      3'd4: begin
        if (y == 0) return 32'hFFFF_FFFF;
        if (ovf) return x;
        p = sx / sy; return p[31:0];
      end
      3'd5: begin
        if (y == 0) return 32'hFFFF_FFFF;
        p = ux / uy; return p[31:0];
      end
      3'd6: begin
        if (y == 0) return x;
        if (ovf) return 32'd0;
        p = sx % sy; return p[31:0];
      end
      default: begin
        if (y == 0) return x;
        p = ux % uy; return p[31:0];
      end
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
    if (f[2] && (y == 0 || ((f == 3'd4 || f == 3'd6) && x == 32'h8000_0000 && y == 32'hFFFF_FFFF)))
      return 1;
`ifdef MULDIV_FAST_MUL_EN
    if (!f[2]) return 1;
`endif
    return 33;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s [%s] observed=%h expected=%h", tag, cur, obs, exp);
    end
  endtask

  // One op from accept to return-to-IDLE; h = number of DONE cycles with hold high.
  task automatic run_op(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y, input int h);
    int          lat;
    logic [31:0] exp;
    lat = ref_lat(f, x, y);
    exp = ref_res(f, x, y);
    cur = $sformatf("f3=%0d a=%h b=%h", f, x, y);
    @(negedge clk);
    start = 1'b1; funct3 = f; a = x; b = y; hold = 1'b0; flush = 1'b0;
    #1;
    chk("stall_accept", ex_stall, 1);
    chk("done_accept", done, 0);
    chk("result_kept", result, last_res);
    for (int k = 1; k <= lat; k++) begin
      @(negedge clk); #1;
      if (k < lat) begin
        chk("stall_busy", ex_stall, 1);
        chk("done_early", done, 0);
      end
    end
    chk("done", done, 1);
    chk("result", result, exp);
    chk("stall_done", ex_stall, 0);
    last_res = exp;
    hold = (h > 0);
    for (int j = 1; j <= h; j++) begin
      @(negedge clk); #1;
      chk("done_held", done, 1);
      chk("result_held", result, exp);
      chk("stall_held", ex_stall, 0);
      hold = (j < h);
    end
    start = 1'b0;
    @(negedge clk); #1;
    chk("no_second_done", done, 0);
    chk("result_idle", result, exp);
  endtask

  initial begin
    logic [2:0]  rf;
    logic [31:0] ra, rb;
    int          sel;

    rst = 1'b1; start = 1'b0; hold = 1'b0; flush = 1'b0; funct3 = '0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    chk("rst_done", done, 0);
    chk("rst_result", result, 0);
    chk("rst_stall", ex_stall, 0);
    rst = 1'b0;

    run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 0);
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    run_op(3'd2, 32'hFFFF_FFFF, 32'd2, 0);
    run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 0);
    run_op(3'd4, -32'sd20, 32'd6, 0);
    run_op(3'd6, -32'sd20, 32'd6, 0);
    run_op(3'd5, 32'd100, 32'd7, 0);
    run_op(3'd7, 32'd100, 32'd7, 0);
    run_op(3'd5, 32'd5, 32'd0, 0);
    run_op(3'd6, 32'd5, 32'd0, 0);
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 1);

    // Flush a DIV at T+10, then start MUL 3*4 at T+11.
    cur = "flush_div";
    @(negedge clk);
    start = 1'b1; funct3 = 3'd4; a = -32'sd20; b = 32'd6;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk); #1;
      chk("flush_pre_done", done, 0);
      chk("flush_pre_stall", ex_stall, 1);
    end
    @(negedge clk);
    flush = 1'b1;
    #1;
    chk("flush_stall", ex_stall, 0);
    chk("flush_done", done, 0);
    run_op(3'd0, 32'd3, 32'd4, 0);

    run_op(3'd0, 32'd6, 32'd7, 3);

    // Reset in the middle of an op discards it and clears result.
    cur = "mid_reset";
    @(negedge clk);
    start = 1'b1; funct3 = 3'd5; a = 32'd1000; b = 32'd3;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #1;
    chk("midrst_done", done, 0);
    chk("midrst_result", result, 0);
    chk("midrst_stall", ex_stall, 0);
    rst = 1'b0;
    last_res = '0;
    repeat (3) begin
      @(negedge clk); #1;
      chk("midrst_quiet", done, 0);
    end

    for (int n = 0; n < 40; n++) begin
      sel = int'($urandom_range(0, 7));
      rf  = 3'($urandom_range(0, 7));
      ra  = $urandom;
      rb  = $urandom;
      case (sel)
        0: rb = '0;
        1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2: begin ra = 32'($urandom_range(0, 40)) - 32'd20; rb = 32'($urandom_range(0, 14)) - 32'd7; end
        default: ;
      endcase
      run_op(rf, ra, rb, int'($urandom_range(0, 2)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
